// File: rtl/inst_encoder.sv
// MIPS32 instruction encoder: turns abstract logic/shift/immediate operations
// (plus the li pseudo-op) into instruction words with byte addresses for ROM fill.
module inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [3:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] imm_i,
  input  logic        addr_clr_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [15:0] word_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  localparam logic [3:0] OP_OR   = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_SLLV = 4'd4;
  localparam logic [3:0] OP_SRLV = 4'd5;
  localparam logic [3:0] OP_SRAV = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_ORI  = 4'd10;
  localparam logic [3:0] OP_ANDI = 4'd11;
  localparam logic [3:0] OP_XORI = 4'd12;
  localparam logic [3:0] OP_LUI  = 4'd13;
  localparam logic [3:0] OP_LI   = 4'd14;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] funct);
    return {6'h00, rs, rt, rd, sa, funct};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] opcode, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

  state_t      state_reg;
  logic [31:0] inst_reg;
  logic [31:0] addr_reg;
  logic [15:0] word_cnt_reg;
  logic [31:0] second_word_reg;
  logic        two_word_reg;
  logic        in_ready_reg;
  logic        inst_valid_reg;

  logic [31:0] first_word_next;
  logic [31:0] second_word_next;
  logic        two_word_next;
  logic        word_accept;

  // Encoding straight from the request fields; only sampled on accept in IDLE.
  always_comb begin
    first_word_next  = 32'h0000_0000;
    second_word_next = 32'h0000_0000;
    two_word_next    = 1'b0;
    case (op_i)
      OP_OR:   first_word_next = r_type(rs_i, rt_i, rd_i, 5'd0, 6'h25);
      OP_AND:  first_word_next = r_type(rs_i, rt_i, rd_i, 5'd0, 6'h24);
      OP_XOR:  first_word_next = r_type(rs_i, rt_i, rd_i, 5'd0, 6'h26);
      OP_NOR:  first_word_next = r_type(rs_i, rt_i, rd_i, 5'd0, 6'h27);
      OP_SLLV: first_word_next = r_type(rs_i, rt_i, rd_i, 5'd0, 6'h04);
      OP_SRLV: first_word_next = r_type(rs_i, rt_i, rd_i, 5'd0, 6'h06);
      OP_SRAV: first_word_next = r_type(rs_i, rt_i, rd_i, 5'd0, 6'h07);
      OP_SLL:  first_word_next = r_type(5'd0, rt_i, rd_i, imm_i[4:0], 6'h00);
      OP_SRL:  first_word_next = r_type(5'd0, rt_i, rd_i, imm_i[4:0], 6'h02);
      OP_SRA:  first_word_next = r_type(5'd0, rt_i, rd_i, imm_i[4:0], 6'h03);
      OP_ORI:  first_word_next = i_type(6'h0D, rs_i, rt_i, imm_i[15:0]);
      OP_ANDI: first_word_next = i_type(6'h0C, rs_i, rt_i, imm_i[15:0]);
      OP_XORI: first_word_next = i_type(6'h0E, rs_i, rt_i, imm_i[15:0]);
      OP_LUI:  first_word_next = i_type(6'h0F, 5'd0, rt_i, imm_i[15:0]);
      OP_LI: begin
        // Pick the shortest expansion that reproduces the 32-bit constant.
        if (imm_i[31:16] == 16'h0000) begin
          first_word_next = i_type(6'h0D, 5'd0, rt_i, imm_i[15:0]);
        end else if (imm_i[15:0] == 16'h0000) begin
          first_word_next = i_type(6'h0F, 5'd0, rt_i, imm_i[31:16]);
        end else begin
          first_word_next  = i_type(6'h0F, 5'd0, rt_i, imm_i[31:16]);
          second_word_next = i_type(6'h0D, rt_i, rt_i, imm_i[15:0]);
          two_word_next    = 1'b1;
        end
      end
      default: first_word_next = 32'h0000_0000;
    endcase
  end

  assign word_accept = inst_valid_reg & inst_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      inst_reg        <= 32'h0000_0000;
      addr_reg        <= BASE_ADDR;
      word_cnt_reg    <= 16'h0000;
      second_word_reg <= 32'h0000_0000;
      two_word_reg    <= 1'b0;
      in_ready_reg    <= 1'b1;
      inst_valid_reg  <= 1'b0;
    end else begin
      if (word_accept) begin
        addr_reg <= addr_reg + 32'd4;
        if (word_cnt_reg != 16'hFFFF) begin
          word_cnt_reg <= word_cnt_reg + 16'd1;
        end
      end
      case (state_reg)
        IDLE: begin
          // addr_reg doubles as the next word's address, so a clear here
          // also places a simultaneously accepted op at BASE_ADDR.
          if (addr_clr_i) begin
            addr_reg <= BASE_ADDR;
          end
          if (in_valid_i) begin
            inst_reg        <= first_word_next;
            second_word_reg <= second_word_next;
            two_word_reg    <= two_word_next;
            state_reg       <= EMIT1;
            in_ready_reg    <= 1'b0;
            inst_valid_reg  <= 1'b1;
          end
        end
        EMIT1: begin
          if (inst_ready_i) begin
            if (two_word_reg) begin
              inst_reg  <= second_word_reg;
              state_reg <= EMIT2;
            end else begin
              state_reg      <= IDLE;
              in_ready_reg   <= 1'b1;
              inst_valid_reg <= 1'b0;
            end
          end
        end
        EMIT2: begin
          if (inst_ready_i) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b1;
            inst_valid_reg <= 1'b0;
            two_word_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg      <= IDLE;
          in_ready_reg   <= 1'b1;
          inst_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o   = in_ready_reg;
  assign inst_valid_o = inst_valid_reg;
  assign inst_o       = inst_reg;
  assign inst_addr_o  = addr_reg;
  assign word_cnt_o   = word_cnt_reg;

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Sequential MIPS32 instruction encoder: the write-side counterpart of the ID-stage decoder. It accepts one abstract operation per handshake and emits the matching 32-bit instruction word(s) with a byte address, for filling instruction memory. The output covers the logic/shift/immediate subset the decoder accepts. It also expands the `li` pseudo-op into one or two real instructions. It sits between a test/boot sequencer and the instruction ROM write port.

## Interface
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word and the value `addr_clr_i` restores.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high (`RstEnable` = 1'b1)
- in_valid_i  in  1  operation request valid
- in_ready_o  out  1  encoder can accept an operation
- op_i  in  4  0 OR, 1 AND, 2 XOR, 3 NOR, 4 SLLV, 5 SRLV, 6 SRAV, 7 SLL, 8 SRL, 9 SRA, 10 ORI, 11 ANDI, 12 XORI, 13 LUI, 14 LI, 15 NOP
- rs_i / rt_i / rd_i  in  5 each  register fields
- imm_i  in  32  immediate: [15:0] for ORI/ANDI/XORI/LUI, [4:0] shift amount for SLL/SRL/SRA, full word for LI
- addr_clr_i  in  1  reload address counter with BASE_ADDR; honoured only in IDLE
- inst_o  out  32  encoded instruction word
- inst_addr_o  out  32  byte address of inst_o
- inst_valid_o  out  1  inst_o/inst_addr_o valid (memory write enable)
- inst_ready_i  in  1  memory accepts the word this cycle
- word_cnt_o  out  16  words accepted since reset, saturating at 16'hFFFF

## Operation
- Encodings use 6-bit funct/opcode fields as hex. SPECIAL = opcode 0.
- Funct values for R-type: OR 25, AND 24, XOR 26, NOR 27, SLLV 04, SRLV 06, SRAV 07, SLL 00, SRL 02, SRA 03.
- R-type logic ops: {000000, rs, rt, rd, 00000, funct}.
- Variable shifts (SLLV/SRLV/SRAV): {000000, rs, rt, rd, 00000, funct}. rs carries the shift-amount register.
- Immediate shifts (SLL/SRL/SRA): {000000, 00000, rt, rd, imm[4:0], funct}. Bits [31:21] are forced to zero.
- I-type: {opcode, rs, rt, imm[15:0]}, with opcode ORI 0D, ANDI 0C, XORI 0E.
- LUI: {0F, 00000, rt, imm[15:0]}.
- NOP encodes as 32'h0000_0000.
- Unused fields are always driven to zero, never copied from inputs.
- LI rt, imm32 expands by value:
  - imm[31:16]==0: single word ORI rt,$0,imm[15:0].
  - else imm[15:0]==0: single word LUI rt,imm[31:16].
  - else two words: LUI rt,imm[31:16] then ORI rt,rt,imm[15:0].
- FSM states:
  - IDLE: in_ready_o=1, inst_valid_o=0.
  - EMIT1: first or only word held on the output.
  - EMIT2: second word of a two-word LI.
- Transitions:
  - IDLE→EMIT1 on in_valid_i&in_ready_o. All needed input fields are latched; inputs are don't-care afterwards.
  - EMIT1→EMIT2 on inst_ready_i when the two-word LI is pending.
  - EMIT1→IDLE on inst_ready_i otherwise.
  - EMIT2→IDLE on inst_ready_i.
- Address counter: +4 on every accepted word (inst_valid_o&inst_ready_i). Wraps modulo 2^32 with no flag.
- addr_clr_i in IDLE loads BASE_ADDR. If it coincides with an accept, the accepted op's first word uses BASE_ADDR. Outside IDLE it is ignored.

## Timing
- Reset values (rst high at an edge):
  - State IDLE, in_ready_o=1, inst_valid_o=0.
  - inst_o=0, inst_addr_o=BASE_ADDR, word_cnt_o=0.
  - Any in-flight LI second word is discarded.
- Reset overrides all other inputs in the same cycle.
- Latency: an op accepted at edge N presents inst_valid_o=1 with the first word from cycle N+1 (registered outputs, no combinational input→output path).
- Output holds: inst_o, inst_addr_o and inst_valid_o stay stable while inst_valid_o=1 and inst_ready_i=0.
- A word transfers at the edge where inst_valid_o&inst_ready_i=1.
- Second LI word appears the cycle after the first word's transfer, at address +4.
- in_ready_o is high only in IDLE and returns high the cycle after the last word's transfer.
- Peak throughput: one single-word op per 2 cycles; a two-word LI takes 3 cycles with no stall.
- inst_ready_i is ignored while inst_valid_o=0.

## Test plan
- Reset, then ORI rt=1 rs=0 imm=16'h1100 with ready held high → inst_o=32'h3401_1100 at BASE_ADDR one cycle after accept; in_ready_o high again 2 cycles after accept; word_cnt_o=1.
- OR rs=1 rt=2 rd=3 → 32'h0022_1825. SLL rt=2 rd=5 imm=8 → 32'h0002_2A00 with bits[31:21]=0. SRAV rs=4 rt=2 rd=6 → 32'h0082_3007.
- LI rt=3 imm=32'h1234_5678 → LUI 32'h3C03_1234 at A, then ORI 32'h3463_5678 at A+4. LI imm=32'h0000_00FF → only 32'h3403_00FF. LI imm=32'hABCD_0000 → only 32'h3C03_ABCD.
- Hold inst_ready_i low 5 cycles during a two-word LI → first word and address stable; second word not shown until first transfers; in_ready_o stays 0 throughout.
- Reset asserted while in EMIT2 → next cycle inst_valid_o=0, inst_addr_o=BASE_ADDR, word_cnt_o=0, in_ready_o=1.
- BASE_ADDR=32'hFFFF_FFF8 with three NOPs → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. addr_clr_i together with the next accept → that word at BASE_ADDR. addr_clr_i during EMIT1 → ignored.
